// File: rtl/aes128_package.sv
// Shared GF(2^4) tower-field types and constants for the AES S-box datapath.
package aes128_package;

  localparam logic [3:0] BV4_ONE                 = 4'hF;
  localparam int         BV4_MUL_PIPE_MIN_STAGES = 1;
  localparam int         BV4_MUL_PIPE_MAX_STAGES = 3;

  // [0]=a2^a0 [1]=a3^a1 [2]=b2^b0 [3]=b3^b1 [4]=[0]^[1] [5]=[2]^[3]
  // [6]=a1^a0 [7]=b1^b0 [8]=a3^a2 [9]=b3^b2
  typedef logic [9:0] bv4_front_t;
  typedef logic [8:0] bv4_mid_t;

endpackage

// File: rtl/bv4_mul_split.sv
// Single-lane GF(2^4) normal-basis multiplier split into front XOR, AND product and back XOR stages.
module bv4_mul_split
  import aes128_package::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output bv4_front_t o_front,
  input  logic [3:0] i_ma,
  input  logic [3:0] i_mb,
  input  bv4_front_t i_mfront,
  output bv4_mid_t   o_mid,
  input  bv4_mid_t   i_mid,
  output logic [3:0] o_c
);

  assign o_front[0] = i_a[2] ^ i_a[0];
  assign o_front[1] = i_a[3] ^ i_a[1];
  assign o_front[2] = i_b[2] ^ i_b[0];
  assign o_front[3] = i_b[3] ^ i_b[1];
  assign o_front[4] = o_front[0] ^ o_front[1];
  assign o_front[5] = o_front[2] ^ o_front[3];
  assign o_front[6] = i_a[1] ^ i_a[0];
  assign o_front[7] = i_b[1] ^ i_b[0];
  assign o_front[8] = i_a[3] ^ i_a[2];
  assign o_front[9] = i_b[3] ^ i_b[2];

  // Low half, high half and the cross term each take three ANDs.
  assign o_mid[0] = i_ma[0] & i_mb[0];
  assign o_mid[1] = i_mfront[6] & i_mfront[7];
  assign o_mid[2] = i_ma[1] & i_mb[1];
  assign o_mid[3] = i_ma[2] & i_mb[2];
  assign o_mid[4] = i_mfront[8] & i_mfront[9];
  assign o_mid[5] = i_ma[3] & i_mb[3];
  assign o_mid[6] = i_mfront[0] & i_mfront[2];
  assign o_mid[7] = i_mfront[4] & i_mfront[5];
  assign o_mid[8] = i_mfront[1] & i_mfront[3];

  assign o_c[0] = i_mid[6] ^ i_mid[8] ^ i_mid[0] ^ i_mid[1];
  assign o_c[1] = i_mid[6] ^ i_mid[7] ^ i_mid[1] ^ i_mid[2];
  assign o_c[2] = i_mid[4] ^ i_mid[3] ^ i_mid[6] ^ i_mid[8];
  assign o_c[3] = i_mid[4] ^ i_mid[5] ^ i_mid[6] ^ i_mid[7];

endmodule

// File: rtl/bv4_mul_pipe.sv
// LANES-wide pipelined GF(2^4) multiplier with valid/ready slots; STAGES selects register cut points.
// Optional squaring mode (in_sqr) is enabled by defining BV4_MUL_PIPE_SQR_EN.
module bv4_mul_pipe
  import aes128_package::*;
#(
  parameter int LANES  = 4,
  parameter int STAGES = 2
) (
  input  logic               in_clock,
  input  logic               in_reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*4-1:0] in_a,
  input  logic [LANES*4-1:0] in_b,
`ifdef BV4_MUL_PIPE_SQR_EN
  input  logic               in_sqr,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*4-1:0] out_c
);

  if (LANES < 1 || LANES > 16) begin : g_bad_lanes
    $error("bv4_mul_pipe: LANES must be 1..16");
  end
  if (STAGES < BV4_MUL_PIPE_MIN_STAGES || STAGES > BV4_MUL_PIPE_MAX_STAGES) begin : g_bad_stages
    $error("bv4_mul_pipe: STAGES must be 1..3");
  end

  logic [LANES-1:0][3:0] w_a, w_b, w_ma, w_mb, w_c, r_c;
  bv4_front_t [LANES-1:0] w_front, w_mfront;
  bv4_mid_t   [LANES-1:0] w_mid, w_bmid;
  logic [STAGES-1:0]      r_vld, w_load, w_prev, w_fill;

  assign w_a = in_a;
`ifdef BV4_MUL_PIPE_SQR_EN
  // Squaring is resolved before the front XORs, so the mode needs no storage downstream.
  assign w_b = in_sqr ? in_a : in_b;
`else
  assign w_b = in_b;
`endif

  // A slot loads when any slot at or beyond it is empty, or the output drains.
  for (genvar k = 0; k < STAGES; k++) begin : g_load
    assign w_load[k] = out_ready | ~(&r_vld[STAGES-1:k]);
  end

  if (STAGES == 1) begin : g_prev1
    assign w_prev = in_valid;
  end else begin : g_prevn
    assign w_prev = {r_vld[STAGES-2:0], in_valid};
  end

  assign w_fill    = w_load & w_prev;
  assign in_ready  = w_load[0];
  assign out_valid = r_vld[STAGES-1];
  assign out_c     = r_c;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    bv4_mul_split u_split (
      .i_a      (w_a[l]),
      .i_b      (w_b[l]),
      .o_front  (w_front[l]),
      .i_ma     (w_ma[l]),
      .i_mb     (w_mb[l]),
      .i_mfront (w_mfront[l]),
      .o_mid    (w_mid[l]),
      .i_mid    (w_bmid[l]),
      .o_c      (w_c[l])
    );
  end

  if (STAGES == 3) begin : g_front_reg
    logic [LANES-1:0][3:0]  r_a, r_b;
    bv4_front_t [LANES-1:0] r_front;
    always_ff @(posedge in_clock) begin
      if (w_fill[0]) begin
        r_a     <= w_a;
        r_b     <= w_b;
        r_front <= w_front;
      end
    end
    assign w_ma     = r_a;
    assign w_mb     = r_b;
    assign w_mfront = r_front;
  end else begin : g_front_comb
    assign w_ma     = w_a;
    assign w_mb     = w_b;
    assign w_mfront = w_front;
  end

  if (STAGES >= 2) begin : g_mid_reg
    bv4_mid_t [LANES-1:0] r_mid;
    always_ff @(posedge in_clock) begin
      if (w_fill[STAGES-2]) r_mid <= w_mid;
    end
    assign w_bmid = r_mid;
  end else begin : g_mid_comb
    assign w_bmid = w_mid;
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      r_vld <= '0;
      r_c   <= '0;
    end else begin
      r_vld <= (r_vld & ~w_load) | (w_prev & w_load);
      if (w_fill[STAGES-1]) r_c <= w_c;
    end
  end

endmodule

// File: tb/tb_bv4_mul_pipe.sv
// Self-checking bench: STAGES=1,2,3 instances (LANES=4) against a bilinear basis-table model of GF(2^4).
module tb_bv4_mul_pipe;

  logic        clk = 1'b0;
  logic        in_reset, in_valid, out_ready;
  logic [15:0] in_a, in_b;
`ifdef BV4_MUL_PIPE_SQR_EN
  logic        in_sqr;
`endif
  logic [2:0]  ir, ov;
  logic [15:0] oc [3];

  always #5 clk = ~clk;

  bv4_mul_pipe #(.LANES(4), .STAGES(1)) u_s1 (
    .in_clock(clk), .in_reset(in_reset), .in_valid(in_valid), .in_ready(ir[0]),
    .in_a(in_a), .in_b(in_b),
`ifdef BV4_MUL_PIPE_SQR_EN
    .in_sqr(in_sqr),
`endif
    .out_valid(ov[0]), .out_ready(out_ready), .out_c(oc[0]));
  bv4_mul_pipe #(.LANES(4), .STAGES(2)) u_s2 (
    .in_clock(clk), .in_reset(in_reset), .in_valid(in_valid), .in_ready(ir[1]),
    .in_a(in_a), .in_b(in_b),
`ifdef BV4_MUL_PIPE_SQR_EN
    .in_sqr(in_sqr),
`endif
    .out_valid(ov[1]), .out_ready(out_ready), .out_c(oc[1]));
  bv4_mul_pipe #(.LANES(4), .STAGES(3)) u_s3 (
    .in_clock(clk), .in_reset(in_reset), .in_valid(in_valid), .in_ready(ir[2]),
    .in_a(in_a), .in_b(in_b),
`ifdef BV4_MUL_PIPE_SQR_EN
    .in_sqr(in_sqr),
`endif
    .out_valid(ov[2]), .out_ready(out_ready), .out_c(oc[2]));

  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [15:0] cur_exp;
  logic        lat_chk;
  logic [15:0] expq [3][0:1023];
  int          expt [3][0:1023];
  int          wp [3], rp [3];
  logic [2:0]  st_prev, acc, ir_obs;
  logic [15:0] pc [3];

  // Product of basis bits e_i * e_j; multiplication is bilinear over these.
  function automatic logic [3:0] bprod(int i, int j);
    case (i * 4 + j)
      0:       return 4'h7;
      1, 4:    return 4'h9;
      2, 8:    return 4'h5;
      3, 12:   return 4'hA;
      5:       return 4'hE;
      6, 9:    return 4'hA;
      7, 13:   return 4'hF;
      10:      return 4'hD;
      11, 14:  return 4'h6;
      15:      return 4'hB;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [3:0] gmul(logic [3:0] a, logic [3:0] b);
    logic [3:0] r = 4'h0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (a[i] && b[j]) r ^= bprod(i, j);
    return r;
  endfunction

  function automatic logic [15:0] ref4(logic [15:0] a, logic [15:0] b);
    logic [15:0] r;
    for (int l = 0; l < 4; l++) r[4*l +: 4] = gmul(a[4*l +: 4], b[4*l +: 4]);
    return r;
  endfunction

  task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut_stages=%0d cyc=%0d got %h want %h", nm, d + 1, cyc, act, exp);
    end
  endtask

  // Scoreboard at the negedge: handshake signals are stable for the coming edge.
  task automatic observe();
    for (int d = 0; d < 3; d++) begin
      if (st_prev[d]) begin
        chk("stall_hold_valid", d, ov[d], 1);
        chk("stall_hold_data", d, oc[d], pc[d]);
      end
      st_prev[d] = ov[d] && !out_ready && !in_reset;
      pc[d]      = oc[d];
      ir_obs[d]  = ir[d];
      acc[d]     = in_valid && ir[d] && !in_reset;
      if (!in_reset && ov[d] && out_ready) begin
        if (rp[d] == wp[d]) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_output dut_stages=%0d cyc=%0d got %h want none", d + 1, cyc, oc[d]);
        end else begin
          chk("data", d, oc[d], expq[d][rp[d] % 1024]);
          if (lat_chk) chk("latency", d, cyc - expt[d][rp[d] % 1024], d + 1);
          rp[d]++;
        end
      end
      if (acc[d]) begin
        expq[d][wp[d] % 1024] = cur_exp;
        expt[d][wp[d] % 1024] = cyc;
        wp[d]++;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(logic [15:0] a, logic [15:0] b, logic sqr);
    in_a = a;
    in_b = b;
`ifdef BV4_MUL_PIPE_SQR_EN
    in_sqr  = sqr;
    cur_exp = ref4(a, sqr ? a : b);
`else
    cur_exp = ref4(a, b);
`endif
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sqr;
    logic [15:0] exp;
  } vec_t;

  vec_t        vt [$];
  logic [15:0] bp_a [8], bp_b [8];

  initial begin
    vt.push_back('{16'hFFFF, 16'h1234, 1'b0, 16'h1234});
    vt.push_back('{16'h0000, 16'hFFFF, 1'b0, 16'h0000});
    vt.push_back('{16'hF321, 16'hF541, 1'b0, 16'hF1A7});
    vt.push_back('{16'hF541, 16'hF321, 1'b0, 16'hF1A7});
    vt.push_back('{16'h8421, 16'h8421, 1'b0, 16'hBDE7});
    vt.push_back('{16'h1234, 16'hFFFF, 1'b0, 16'h1234});
`ifdef BV4_MUL_PIPE_SQR_EN
    vt.push_back('{16'h0001, 16'h0009, 1'b1, 16'h0007});
    vt.push_back('{16'h8421, 16'h0000, 1'b1, 16'hBDE7});
`endif
    for (int d = 0; d < 3; d++) begin wp[d] = 0; rp[d] = 0; end
    st_prev = '0; lat_chk = 1'b0;
    in_reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(16'h0, 16'h0, 1'b0);

    // Reset state
    tick(); tick();
    for (int d = 0; d < 3; d++) begin
      chk("rst_out_valid", d, ov[d], 0);
      chk("rst_out_c", d, oc[d], 0);
    end
    in_reset = 1'b0;
    for (int d = 0; d < 3; d++) chk("ready_after_rst", d, ir[d], 1);

    // Directed vectors, one at a time, with exact latency
    lat_chk = 1'b1;
    foreach (vt[i]) begin
      in_valid = 1'b1;
      drive(vt[i].a, vt[i].b, vt[i].sqr);
      cur_exp = vt[i].exp;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
    end

    // Every (a,b) pair on every lane, back-to-back
    for (int t = 0; t < 256; t++) begin
      logic [15:0] a, b;
      for (int l = 0; l < 4; l++) begin
        logic [7:0] p;
        p = 8'((t + 64 * l) & 255);
        a[4*l +: 4] = p[7:4];
        b[4*l +: 4] = p[3:0];
      end
      in_valid = 1'b1;
      drive(a, b, 1'b0);
      for (int d = 0; d < 3; d++) chk("stream_ready", d, ir[d], 1);
      tick();
    end
    in_valid = 1'b0;
    repeat (5) tick();

    // Random traffic with random backpressure
    lat_chk = 1'b0;
    for (int t = 0; t < 300; t++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      drive(16'($urandom), 16'($urandom), 1'($urandom));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) tick();

    // Eight transactions, output stalled for five cycles mid-stream
    for (int i = 0; i < 8; i++) begin bp_a[i] = 16'($urandom); bp_b[i] = 16'($urandom); end
    begin
      int sent = 0, k = 0;
      while (sent < 8 && k < 100) begin
        out_ready = !(k >= 2 && k < 7);
        in_valid  = 1'b1;
        drive(bp_a[sent], bp_b[sent], 1'b0);
        tick();
        if (k >= 3 && k <= 6) chk("full_in_ready", 2, ir_obs[2], 0);
        if (acc[2]) sent++;
        k++;
      end
      if (sent < 8) begin
        n_chk++; n_fail++;
        $display("FAIL backpressure_timeout got %0d want 8", sent);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) tick();
    for (int d = 0; d < 3; d++) chk("drained_bp", d, rp[d], wp[d]);

    // Reset with transactions in flight and a simultaneous input
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      drive(16'($urandom), 16'($urandom), 1'b0);
      tick();
    end
    in_reset = 1'b1;
    drive(16'hFFFF, 16'h5A5A, 1'b0);
    tick();
    for (int d = 0; d < 3; d++) begin
      chk("midrst_out_valid", d, ov[d], 0);
      chk("midrst_out_c", d, oc[d], 0);
      rp[d] = wp[d];
    end
    in_reset = 1'b0; in_valid = 1'b0;
    repeat (6) begin
      tick();
      for (int d = 0; d < 3; d++) chk("no_ghost", d, ov[d], 0);
    end

`ifdef BV4_MUL_PIPE_SQR_EN
    // Alternating mode bit every cycle
    lat_chk = 1'b1;
    for (int t = 0; t < 16; t++) begin
      in_valid = 1'b1;
      drive(16'($urandom), 16'($urandom), 1'(t & 1));
      tick();
    end
    in_valid = 1'b0;
    repeat (5) tick();
`endif

    for (int d = 0; d < 3; d++) chk("final_drain", d, rp[d], wp[d]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
